// File: rtl/sd_pkg.sv
// Shared types and helpers for the SD byte/word buffer arbiter.
// Lane mapping lives here so the top and any future peers agree on byte order.
package sd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    TX_SHIFT = 2'd1,
    RX_FILL  = 2'd2,
    RX_OUT   = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_TX = 1'b0,
    GRANT_RX = 1'b1
  } grant_t;

  localparam int BYTES_PER_WORD = 4;

  function automatic logic [1:0] lane_of(input logic [1:0] idx, input logic msb_first);
    return msb_first ? (2'd3 - idx) : idx;
  endfunction

  function automatic logic [31:0] place_byte(input logic [1:0] lane, input logic [7:0] data);
    logic [31:0] word;
    word = 32'h0000_0000;
    word[{lane, 3'b000} +: 8] = data;
    return word;
  endfunction

endpackage

// File: rtl/byte_lane_buf.sv
// 32-bit shared buffer with a full-word load port and a single-lane byte write port.
// A full load wins over a byte write in the same cycle.
module byte_lane_buf
  import sd_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_en,
  input  logic [8*BYTES_PER_WORD-1:0]   load_data,
  input  logic                          wr_en,
  input  logic [1:0]                    wr_lane,
  input  logic [7:0]                    wr_data,
  output logic [8*BYTES_PER_WORD-1:0]   data
);

  logic [8*BYTES_PER_WORD-1:0] data_r;

  // buffer storage
  always_ff @(posedge clk) begin
    if (rst) begin
      data_r <= '0;
    end else if (load_en) begin
      data_r <= load_data;
    end else if (wr_en) begin
      data_r[{wr_lane, 3'b000} +: 8] <= wr_data;
    end else begin
      data_r <= data_r;
    end
  end

  assign data = data_r;

endmodule

// File: rtl/sd_byte_word_arbiter.sv
// Arbitrates the shared byte-lane buffer between the TX word path and the RX byte path,
// serialising TX words into bytes and packing RX bytes into words.
module sd_byte_word_arbiter
  import sd_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] tx_word,
  input  logic        tx_word_valid,
  output logic        tx_word_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_byte_valid,
  input  logic        tx_byte_ready,
  input  logic [7:0]  rx_byte,
  input  logic        rx_byte_last,
  input  logic        rx_byte_valid,
  output logic        rx_byte_ready,
  output logic [31:0] rx_word,
  output logic [2:0]  rx_word_bytes,
  output logic        rx_word_valid,
  input  logic        rx_word_ready
);

  state_t      state_r, state_nxt_s;
  grant_t      last_grant_r;
  logic [1:0]  idx_r;
  logic [2:0]  cnt_r;
  logic        grant_tx_s, grant_rx_s;
  logic        tx_accept_s, rx_accept_s, rx_fill_accept_s;
  logic        load_en_s, wr_en_s;
  logic [1:0]  wr_lane_s, rd_lane_s;
  logic [31:0] load_data_s, buf_data_s;

  // round-robin grant from the request valids; only meaningful in IDLE
  always_comb begin
    grant_tx_s = 1'b0;
    grant_rx_s = 1'b0;
    if (tx_word_valid && rx_byte_valid) begin
      if (last_grant_r == GRANT_RX) begin
        grant_tx_s = 1'b1;
      end else begin
        grant_rx_s = 1'b1;
      end
    end else begin
      grant_tx_s = tx_word_valid;
      grant_rx_s = rx_byte_valid;
    end
  end

  assign tx_accept_s      = tx_word_valid & tx_word_ready;
  assign rx_accept_s      = rx_byte_valid & rx_byte_ready & (state_r == IDLE);
  assign rx_fill_accept_s = rx_byte_valid & (state_r == RX_FILL);

  assign load_en_s   = tx_accept_s | rx_accept_s;
  assign load_data_s = tx_accept_s ? tx_word : place_byte(lane_of(2'd0, MSB_FIRST), rx_byte);
  assign wr_en_s     = rx_fill_accept_s;
  assign wr_lane_s   = lane_of(cnt_r[1:0], MSB_FIRST);
  assign rd_lane_s   = lane_of(idx_r, MSB_FIRST);

  byte_lane_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en_s),
    .load_data (load_data_s),
    .wr_en     (wr_en_s),
    .wr_lane   (wr_lane_s),
    .wr_data   (rx_byte),
    .data      (buf_data_s)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (tx_accept_s) begin
          state_nxt_s = TX_SHIFT;
        end else if (rx_accept_s) begin
          state_nxt_s = rx_byte_last ? RX_OUT : RX_FILL;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      TX_SHIFT: begin
        if (tx_byte_ready && (idx_r == 2'(BYTES_PER_WORD - 1))) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = TX_SHIFT;
        end
      end
      RX_FILL: begin
        if (rx_fill_accept_s && (rx_byte_last || (cnt_r == 3'(BYTES_PER_WORD - 1)))) begin
          state_nxt_s = RX_OUT;
        end else begin
          state_nxt_s = RX_FILL;
        end
      end
      RX_OUT: begin
        if (rx_word_ready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RX_OUT;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // byte index, fill count and last-served requester
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_r        <= 2'd0;
      cnt_r        <= 3'd0;
      last_grant_r <= GRANT_RX;
    end else if (tx_accept_s) begin
      idx_r        <= 2'd0;
      last_grant_r <= GRANT_TX;
    end else if (rx_accept_s) begin
      cnt_r        <= 3'd1;
      last_grant_r <= GRANT_RX;
    end else if ((state_r == TX_SHIFT) && tx_byte_ready) begin
      idx_r <= idx_r + 2'd1;
    end else if (rx_fill_accept_s) begin
      cnt_r <= cnt_r + 3'd1;
    end else begin
      idx_r <= idx_r;
    end
  end

  // stream outputs; data buses read zero outside their valid state
  always_comb begin
    tx_word_ready = (state_r == IDLE) & grant_tx_s;
    rx_byte_ready = ((state_r == IDLE) & grant_rx_s) | (state_r == RX_FILL);
    tx_byte_valid = 1'b0;
    tx_byte       = 8'h00;
    rx_word_valid = 1'b0;
    rx_word       = 32'h0000_0000;
    rx_word_bytes = 3'd0;
    case (state_r)
      TX_SHIFT: begin
        tx_byte_valid = 1'b1;
        tx_byte       = buf_data_s[{rd_lane_s, 3'b000} +: 8];
      end
      RX_OUT: begin
        rx_word_valid = 1'b1;
        rx_word       = buf_data_s;
        rx_word_bytes = cnt_r;
      end
      default: begin
        tx_byte_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_sd_byte_word_arbiter.sv
// Scoreboard bench: two arbiters (MSB-first and LSB-first) share one stimulus stream and
// are checked against a transaction-level model of grants, byte order and packing.
module tb_sd_byte_word_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tx_word = 32'h0;
  logic        tx_word_valid = 1'b0;
  logic        tx_byte_ready = 1'b0;
  logic [7:0]  rx_byte = 8'h0;
  logic        rx_byte_last = 1'b0;
  logic        rx_byte_valid = 1'b0;
  logic        rx_word_ready = 1'b0;
  int          cyc = 0;

  logic        m_txwr, m_txbv, m_rxbr, m_rxwv, l_txwr, l_txbv, l_rxbr, l_rxwv;
  logic [7:0]  m_txb, l_txb;
  logic [31:0] m_rxw, l_rxw;
  logic [2:0]  m_rxn, l_rxn;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sd_byte_word_arbiter #(.MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .tx_word(tx_word), .tx_word_valid(tx_word_valid), .tx_word_ready(m_txwr),
    .tx_byte(m_txb), .tx_byte_valid(m_txbv), .tx_byte_ready(tx_byte_ready),
    .rx_byte(rx_byte), .rx_byte_last(rx_byte_last), .rx_byte_valid(rx_byte_valid), .rx_byte_ready(m_rxbr),
    .rx_word(m_rxw), .rx_word_bytes(m_rxn), .rx_word_valid(m_rxwv), .rx_word_ready(rx_word_ready));

  sd_byte_word_arbiter #(.MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .tx_word(tx_word), .tx_word_valid(tx_word_valid), .tx_word_ready(l_txwr),
    .tx_byte(l_txb), .tx_byte_valid(l_txbv), .tx_byte_ready(tx_byte_ready),
    .rx_byte(rx_byte), .rx_byte_last(rx_byte_last), .rx_byte_valid(rx_byte_valid), .rx_byte_ready(l_rxbr),
    .rx_word(l_rxw), .rx_word_bytes(l_rxn), .rx_word_valid(l_rxwv), .rx_word_ready(rx_word_ready));

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- reference model ----------------
  typedef enum {M_IDLE, M_TX, M_FILL, M_OUT} mphase_t;
  typedef struct { logic [31:0] w; logic [2:0] n; } rxw_t;

  mphase_t    m_ph = M_IDLE;
  bit         m_last_tx = 1'b0;
  int         m_txcnt = 0;
  logic [7:0] m_rx[$];
  logic [7:0] exp_tx_m[$], exp_tx_l[$];
  rxw_t       exp_rx_m[$], exp_rx_l[$];

  task automatic model_close_rx();
    rxw_t em, el;
    em.w = 32'h0; el.w = 32'h0;
    em.n = 3'(m_rx.size()); el.n = 3'(m_rx.size());
    foreach (m_rx[i]) begin
      em.w = em.w | ({24'h0, m_rx[i]} << (8 * (3 - i)));
      el.w = el.w | ({24'h0, m_rx[i]} << (8 * i));
    end
    exp_rx_m.push_back(em);
    exp_rx_l.push_back(el);
    m_ph = M_OUT;
  endtask

  // model: checks handshake/valid signals, then advances on the events due at the next edge
  always @(negedge clk) begin
    logic exp_txr, exp_rxr;
    exp_txr = 1'b0;
    exp_rxr = 1'b0;
    if (m_ph == M_IDLE) begin
      exp_txr = tx_word_valid && (!rx_byte_valid || !m_last_tx);
      exp_rxr = rx_byte_valid && (!tx_word_valid || m_last_tx);
    end else if (m_ph == M_FILL) begin
      exp_rxr = 1'b1;
    end
    check("tx_word_ready_m", m_txwr, exp_txr);
    check("rx_byte_ready_m", m_rxbr, exp_rxr);
    check("tx_byte_valid_m", m_txbv, m_ph == M_TX);
    check("rx_word_valid_m", m_rxwv, m_ph == M_OUT);
    check("tx_word_ready_l", l_txwr, exp_txr);
    check("rx_byte_ready_l", l_rxbr, exp_rxr);
    check("tx_byte_valid_l", l_txbv, m_ph == M_TX);
    check("rx_word_valid_l", l_rxwv, m_ph == M_OUT);
    if (rst) begin
      m_ph = M_IDLE; m_last_tx = 1'b0; m_txcnt = 0;
      m_rx.delete(); exp_tx_m.delete(); exp_tx_l.delete(); exp_rx_m.delete(); exp_rx_l.delete();
    end else begin
      case (m_ph)
        M_IDLE: begin
          if (exp_txr) begin
            for (int i = 0; i < 4; i++) begin
              exp_tx_m.push_back(8'(tx_word >> (8 * (3 - i))));
              exp_tx_l.push_back(8'(tx_word >> (8 * i)));
            end
            m_ph = M_TX; m_txcnt = 0; m_last_tx = 1'b1;
          end else if (exp_rxr) begin
            m_rx.delete(); m_rx.push_back(rx_byte); m_last_tx = 1'b0;
            if (rx_byte_last) model_close_rx(); else m_ph = M_FILL;
          end
        end
        M_TX: if (tx_byte_ready) begin
          m_txcnt++;
          if (m_txcnt == 4) m_ph = M_IDLE;
        end
        M_FILL: if (rx_byte_valid) begin
          m_rx.push_back(rx_byte);
          if (rx_byte_last || m_rx.size() == 4) model_close_rx();
        end
        M_OUT: if (rx_word_ready) m_ph = M_IDLE;
        default: m_ph = M_IDLE;
      endcase
    end
  end

  // ---------------- monitor ----------------
  logic        h_tx = 1'b0, h_rx = 1'b0;
  logic [7:0]  h_txb_m, h_txb_l;
  logic [31:0] h_rxw_m, h_rxw_l;
  logic [2:0]  h_rxn_m;

  // monitor: pops expectations on output handshakes and checks hold-stability under backpressure
  always @(negedge clk) begin
    rxw_t e;
    if (!rst) begin
      if (h_tx && m_txbv) begin
        check("tx_byte_hold_m", m_txb, h_txb_m);
        check("tx_byte_hold_l", l_txb, h_txb_l);
      end
      if (h_rx && m_rxwv) begin
        check("rx_word_hold_m", m_rxw, h_rxw_m);
        check("rx_word_hold_l", l_rxw, h_rxw_l);
        check("rx_bytes_hold_m", m_rxn, h_rxn_m);
      end
      if (m_txbv && tx_byte_ready) begin
        if (exp_tx_m.size() == 0) fail_now("tx_byte_m unexpected byte");
        else check("tx_byte_m", m_txb, exp_tx_m.pop_front());
      end
      if (l_txbv && tx_byte_ready) begin
        if (exp_tx_l.size() == 0) fail_now("tx_byte_l unexpected byte");
        else check("tx_byte_l", l_txb, exp_tx_l.pop_front());
      end
      if (m_rxwv && rx_word_ready) begin
        if (exp_rx_m.size() == 0) fail_now("rx_word_m unexpected word");
        else begin
          e = exp_rx_m.pop_front();
          check("rx_word_m", m_rxw, e.w);
          check("rx_word_bytes_m", m_rxn, e.n);
        end
      end
      if (l_rxwv && rx_word_ready) begin
        if (exp_rx_l.size() == 0) fail_now("rx_word_l unexpected word");
        else begin
          e = exp_rx_l.pop_front();
          check("rx_word_l", l_rxw, e.w);
          check("rx_word_bytes_l", l_rxn, e.n);
        end
      end
    end
    h_tx = !rst && m_txbv && !tx_byte_ready;
    h_rx = !rst && m_rxwv && !rx_word_ready;
    h_txb_m = m_txb; h_txb_l = l_txb;
    h_rxw_m = m_rxw; h_rxw_l = l_rxw; h_rxn_m = m_rxn;
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tx_send(input logic [31:0] w, output int acc_cyc);
    bit got;
    got = 1'b0;
    acc_cyc = -1;
    tx_word = w;
    tx_word_valid = 1'b1;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (m_txwr) begin got = 1'b1; acc_cyc = cyc; end
    end
    if (!got) fail_now("tx_send timeout");
    step();
    tx_word_valid = 1'b0;
  endtask

  task automatic rx_send(input logic [7:0] b, input logic last, output int acc_cyc);
    bit got;
    got = 1'b0;
    acc_cyc = -1;
    rx_byte = b;
    rx_byte_last = last;
    rx_byte_valid = 1'b1;
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      if (m_rxbr) begin got = 1'b1; acc_cyc = cyc; end
    end
    if (!got) fail_now("rx_send timeout");
    step();
    rx_byte_valid = 1'b0;
    rx_byte_last = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  initial begin
    int n0, n1, nv;
    bit got, tacc, racc;
    logic [7:0] rxs[4];

    // reset values
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    check("reset tx_byte", m_txb, 32'h0);
    check("reset rx_word", m_rxw, 32'h0);
    check("reset rx_word_bytes", m_rxn, 32'h0);
    check("reset rx_word_l", l_rxw, 32'h0);
    step();
    rst = 1'b0;
    tx_byte_ready = 1'b1;
    rx_word_ready = 1'b1;
    idle(2);

    // TX serialisation and 5-cycle word period
    tx_send(32'h1122_3344, n0);
    tx_send(32'h5566_7788, n1);
    check("tx word period", 32'(n1 - n0), 32'd5);
    idle(8);

    // RX full word with backpressure
    rx_word_ready = 1'b0;
    rxs[0] = 8'hAA; rxs[1] = 8'hBB; rxs[2] = 8'hCC; rxs[3] = 8'hDD;
    rx_send(rxs[0], 1'b0, n0);
    for (int i = 1; i < 4; i++) rx_send(rxs[i], 1'b0, n1);
    got = 1'b0;
    nv = -1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (m_rxwv) begin got = 1'b1; nv = cyc; end
    end
    if (!got) fail_now("rx_word_valid timeout");
    check("rx latency", 32'(nv - n0), 32'd4);
    idle(3);
    @(negedge clk);
    check("rx_byte_ready during hold", m_rxbr, 32'd0);
    step();
    rx_word_ready = 1'b1;
    idle(3);

    // short RX word
    rx_send(8'h5A, 1'b0, n0);
    rx_send(8'h6B, 1'b1, n0);
    idle(4);

    // reset mid-RX, then a fresh word
    rx_send(8'h01, 1'b0, n0);
    rx_send(8'h02, 1'b0, n0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rx_word_valid after reset", m_rxwv, 32'd0);
    step();
    rx_send(8'h10, 1'b0, n0);
    rx_send(8'h20, 1'b0, n0);
    rx_send(8'h30, 1'b0, n0);
    rx_send(8'h40, 1'b0, n0);
    idle(4);

    // contention right after reset: TX first
    rst = 1'b1;
    step();
    rst = 1'b0;
    tx_word = $urandom;
    tx_word_valid = 1'b1;
    rx_byte = 8'($urandom);
    rx_byte_last = 1'b0;
    rx_byte_valid = 1'b1;
    @(negedge clk);
    check("contention tx wins", m_txwr, 32'd1);
    check("contention rx waits", m_rxbr, 32'd0);

    // randomized traffic with backpressure and occasional reset
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      tacc = tx_word_valid && m_txwr;
      racc = rx_byte_valid && m_rxbr;
      step();
      rst = ($urandom_range(0, 299) == 0);
      if (!tx_word_valid || tacc) begin
        tx_word_valid = ($urandom_range(0, 2) != 0);
        tx_word = $urandom;
      end
      if (!rx_byte_valid || racc) begin
        rx_byte_valid = ($urandom_range(0, 2) != 0);
        rx_byte = 8'($urandom);
        rx_byte_last = ($urandom_range(0, 3) == 0);
      end
      tx_byte_ready = ($urandom_range(0, 1) == 1);
      rx_word_ready = ($urandom_range(0, 1) == 1);
    end

    // drain
    rst = 1'b0;
    tx_word_valid = 1'b0;
    rx_byte_valid = 1'b0;
    rx_byte_last = 1'b0;
    tx_byte_ready = 1'b1;
    rx_word_ready = 1'b1;
    idle(12);
    rx_send(8'hE1, 1'b1, n0);
    idle(4);
    check("tx queue drained m", exp_tx_m.size(), 32'd0);
    check("tx queue drained l", exp_tx_l.size(), 32'd0);
    check("rx queue drained m", exp_rx_m.size(), 32'd0);
    check("rx queue drained l", exp_rx_l.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sd_byte_word_arbiter.md
# sd_byte_word_arbiter

Controller for the shared 32-bit byte-lane buffer in the SD data path. Two requesters share one buffer: a TX word path (32-bit word in, serialised as 4 bytes toward the SD shifter) and an RX byte path (bytes from the SD shifter, packed into a 32-bit word for the host FIFO). The block grants the buffer to one requester at a time, sequences the byte-lane writes and reads, and presents valid/ready handshakes on all four streams.

## Interface
- MSB_FIRST, 1, byte order on the byte streams: 1 = bits [31:24] first (SD wire order), 0 = bits [7:0] first
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- tx_word  in  32  word to serialise
- tx_word_valid  in  1  tx_word is valid; must not depend on tx_word_ready
- tx_word_ready  out  1  word accepted when valid&ready
- tx_byte  out  8  serialised byte
- tx_byte_valid  out  1  tx_byte is valid
- tx_byte_ready  in  1  downstream accepts tx_byte
- rx_byte  in  8  incoming byte
- rx_byte_last  in  1  qualifies rx_byte as the final byte of a short word
- rx_byte_valid  in  1  rx_byte is valid; must not depend on rx_byte_ready
- rx_byte_ready  out  1  byte accepted when valid&ready
- rx_word  out  32  packed word; unfilled lanes are zero
- rx_word_bytes  out  3  number of valid bytes in rx_word, 1..4
- rx_word_valid  out  1  rx_word is valid
- rx_word_ready  in  1  upstream accepts rx_word

## Operation
- States: IDLE, TX_SHIFT, RX_FILL, RX_OUT.
- Lane mapping for byte index i (0..3): lane = MSB_FIRST ? 3-i : i; lane k = bits [8k+7:8k].
- IDLE arbitration (combinational from the valids): single requester wins. With both requesting, the requester not served last wins. last_grant register resets to RX, so TX wins the first contention.
- tx_word_ready = IDLE & grant_tx. rx_byte_ready = (IDLE & grant_rx) | RX_FILL. No other readies.
- TX accept in IDLE: buffer loads tx_word in full; idx <= 0; last_grant <= TX; state -> TX_SHIFT.
- TX_SHIFT: tx_byte_valid = 1, tx_byte = lane(idx). On handshake, idx increments. The handshake at idx=3 returns the state to IDLE.
- RX accept in IDLE: buffer does a full load of zero with rx_byte in lane(0); cnt <= 1; last_grant <= RX. If rx_byte_last, the state goes to RX_OUT; otherwise it goes to RX_FILL.
- RX_FILL: each accepted byte is written to lane(cnt) and cnt increments. When the accepted byte brings cnt to 4, or when rx_byte_last is set, the state goes to RX_OUT.
- RX_OUT: rx_word_valid = 1, rx_word = buffer, rx_word_bytes = cnt. On handshake the state returns to IDLE.
- rx_byte_last on the 4th byte has the same effect as a normal 4th byte.
- tx_byte_valid and rx_word_valid are 0 in all other states. Outputs hold stable while valid is high and ready is low.

## Timing
- Reset values: state IDLE, buffer 0, idx 0, cnt 0, last_grant RX, tx_byte_valid 0, rx_word_valid 0, tx_byte 0, rx_word 0, rx_word_bytes 0.
- The readies in IDLE are combinational from the valids. All other outputs are registered-state-derived.
- TX latency: word handshake in cycle N gives first tx_byte_valid in N+1. With tx_byte_ready held at 1, bytes go out in N+1..N+4. tx_word_ready is next high in N+5, so the minimum period is 5 cycles per word.
- RX latency: with 4 back-to-back bytes in cycles N..N+3, rx_word_valid is high in N+4.
- Backpressure on either output holds the state indefinitely. The other requester is not served until the state returns to IDLE; there is no pre-emption.
- rst asserted mid-transaction abandons the transaction. No partial word or byte is emitted, and all values return to their reset values on the next edge.

## Structure
- Shared package sd_pkg: state enum (IDLE, TX_SHIFT, RX_FILL, RX_OUT), grant enum (GRANT_TX, GRANT_RX), constant BYTES_PER_WORD = 4.
- One sub-module, byte_lane_buf: a 32-bit register with a full-word load port and a single-lane byte write port (lane select plus 8-bit data). Full load takes priority over byte write. It has a synchronous reset to 0.
- The arbiter FSM, idx/cnt counters and lane mapping live in the top.

## Test plan
- Reset, then tx_word=0x11223344 with MSB_FIRST=1 and tx_byte_ready=1 → tx_byte sequence 0x11,0x22,0x33,0x44 in 4 consecutive cycles; tx_word_ready high again 5 cycles after accept.
- MSB_FIRST=1, rx bytes 0xAA,0xBB,0xCC,0xDD → rx_word=0xAABBCCDD, rx_word_bytes=4. Hold rx_word_ready=0 for 3 cycles → output stable and rx_byte_ready=0.
- Short RX: 0x5A, then 0x6B with rx_byte_last, MSB_FIRST=1 → rx_word=0x5A6B0000, rx_word_bytes=2. Repeat with MSB_FIRST=0 → rx_word=0x00006B5A.
- Simultaneous tx_word_valid and rx_byte_valid after reset → TX granted first. After the TX word completes and both are still pending, RX is granted, then TX, alternating.
- Randomly toggle tx_byte_ready during TX → each byte is held until its handshake, with no byte skipped or duplicated.
- Assert rst after 2 of 4 RX bytes → no rx_word_valid. After release, a fresh 4-byte word packs correctly from lane(0).
